spike_event_arbiter: RTL
========================

Name: spike_event_arbiter

Overview:
- Sits after processing_system.
- Captures per-unit spike detections and their 2-bit event codes from spike_detection_array / event_out_array, timestamps each one in sample counts, and holds it in a one-deep slot per unit.
- A round-robin arbiter serialises the slots onto one valid/ready event stream shared by all units.
- Tracks events lost to slot overflow.

Parameters:
- NUM_UNITS, 4, number of spike-detection units; must be ≥2.
- EVT_WIDTH, 2, event code width per unit.
- TS_WIDTH, 16, sample timestamp counter width.
- DROP_WIDTH, 8, saturating drop counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; when low, arriving spikes are ignored.
- write_sample_in  in  1  sample strobe, same signal that drives processing_system; advances the timestamp.
- spike_detection_array  in  NUM_UNITS  per-unit spike flag.
- event_out_array  in  EVT_WIDTH*NUM_UNITS  per-unit event code; unit i occupies bits [EVT_WIDTH*i +: EVT_WIDTH].
- evt_valid  out  1  output event valid.
- evt_ready  in  1  consumer ready.
- evt_unit  out  $clog2(NUM_UNITS)  source unit of the presented event.
- evt_code  out  EVT_WIDTH  captured event code.
- evt_timestamp  out  TS_WIDTH  sample count at capture.
- drop_count  out  DROP_WIDTH  saturating count of dropped events.
- overflow  out  1  sticky; set when any drop occurs.
- clear_overflow  in  1  clears overflow and drop_count.

Behaviour:
- Reset (rst=0, async):
  - Outputs: evt_valid=0, evt_unit=0, evt_code=0, evt_timestamp=0, drop_count=0, overflow=0.
  - Internal state: ts counter=0, all pending=0, last_grant=NUM_UNITS-1, state=IDLE.
  - evt_valid deasserts immediately; any in-flight event is discarded.
- Timestamp counter:
  - Increments on each clk edge with write_sample_in=1; wraps modulo 2^TS_WIDTH.
  - A captured event takes the counter value before that cycle's increment.
- Capture, per unit i, per cycle:
  - Condition: enable=1 and spike_detection_array[i]=1.
  - Effect: code_q[i] and ts_q[i] are written and pending[i] is set.
  - The code is captured as-is; 0 is a legal code.
- Slot overflow:
  - If pending[i]=1 and slot i is not being loaded into the output register this cycle, the new spike is dropped and the slot keeps its old contents.
  - drop_count += number of units dropped this cycle, saturating at all-ones. overflow is set.
  - If slot i is being loaded this same cycle, the new spike is accepted into the slot (no drop).
- Counter clear:
  - clear_overflow=1 zeroes drop_count and overflow.
  - A drop in the same cycle wins: overflow=1 and drop_count equals that cycle's drops.
- Round-robin selection (combinational):
  - Scan the eligible mask starting at (last_grant+1) mod NUM_UNITS; the first set bit is the grant.
  - Eligible mask = pending as registered at the start of the cycle; same-cycle arrivals are not eligible.
- FSM, states IDLE and PRESENT:
  - IDLE: if any eligible unit, load the output register (evt_unit, evt_code, evt_timestamp) from the granted slot, clear pending[grant], set last_grant=grant, set evt_valid=1, go to PRESENT. Otherwise stay.
  - PRESENT, evt_ready=0: outputs held stable; no new load.
  - PRESENT, evt_ready=1 (handshake): if any eligible unit, load the next event in the same edge; evt_valid stays 1 (back-to-back, one event per cycle). Otherwise evt_valid=0, go to IDLE.
- Latency: spike sampled at edge k; with the arbiter idle, evt_valid=1 after edge k+1.
- Drain: enable=0 does not stall arbitration; pending slots still drain.
- Output stability: evt_* must not change while evt_valid=1 and evt_ready=0.

Decomposition:
- Package spike_event_pkg: EVT_WIDTH default, arbiter state enum (ARB_IDLE, ARB_PRESENT), and function unit_idx_w(n) returning $clog2(n).
- Sub-module rr_select: purely combinational rotate-priority picker with parameter N, inputs req[N] and last[$clog2(N)], outputs gnt_idx and any.
- Remaining logic (slots, counters, FSM) stays in spike_event_arbiter.

Test Plan:
- Single event: ts counter=5 via five strobes, unit 2 spikes with code 2'b10, evt_ready=1 → two edges later evt_valid=1, evt_unit=2, evt_code=2'b10, evt_timestamp=5; evt_valid=0 the following cycle.
- Fairness: all 4 units spike in one cycle, evt_ready=1 → units 0,1,2,3 on consecutive cycles. All spike again → order continues from 0, then again 0,1,2,3 after last_grant=3.
- Backpressure: evt_ready=0 for 10 cycles with unit 1 pending → outputs constant throughout. Unit 1 spikes again during the stall → accepted, no drop (slot was freed at load). A third spike → drop_count=1, overflow=1.
- Saturation and clear: unit 0 overflowed 300 times with DROP_WIDTH=8 → drop_count=255. clear_overflow → 0. clear_overflow simultaneous with a drop → drop_count=1, overflow=1.
- Enable and wrap: enable=0 with spikes → no pending and no drops. Counter at 16'hFFFF plus one strobe → next capture has timestamp 0.
- Async reset mid-stream: rst=0 while evt_valid=1 → evt_valid=0 without waiting for a clock. After release, the first grant goes to the lowest-indexed pending unit.

Source files
------------

// File: rtl/spike_event_pkg.sv
// rtl/spike_event_pkg.sv - shared types and helpers for the spike event arbiter
//
// Purpose : default event-code width, arbiter state encoding and the
//           unit-index width helper used by spike_event_arbiter and rr_select.
// Ports   : none (package).

package spike_event_pkg;

   localparam int EVT_WIDTH_DEF = 2;

   typedef enum logic [0:0] {
      ARB_IDLE    = 1'b0,
      ARB_PRESENT = 1'b1
   } arb_state_e;

   // Width of an index able to name any of n units.
   function automatic int unit_idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational rotate-priority request picker
//
// Purpose : finds the first set request scanning upward from last+1 (mod N).
// Ports   : req     - request mask, one bit per unit
//           last    - index granted most recently
//           gnt_idx - index of the winning request (0 when none)
//           any     - at least one request is set

module rr_select
   import spike_event_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]               req,
   input  logic [unit_idx_w(N)-1:0]   last,
   output logic [unit_idx_w(N)-1:0]   gnt_idx,
   output logic                       any
);

   localparam int IW = unit_idx_w(N);

   always_comb begin
      int idx;
      idx     = 0;
      gnt_idx = '0;
      any     = 1'b0;
      // Offset k=0 is the unit right after the last winner, so the last
      // winner itself is considered only after every other unit.
      for (int k = 0; k < N; k++) begin
         idx = (int'(last) + 1 + k) % N;
         if (!any && req[idx]) begin
            any     = 1'b1;
            gnt_idx = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/spike_event_arbiter.sv
// rtl/spike_event_arbiter.sv - timestamped per-unit spike capture with round-robin output
//
// Purpose : captures spike event codes per unit into one-deep slots stamped
//           with the sample counter, serialises them onto a valid/ready
//           stream and counts events lost to full slots.
// Ports   : clk, rst (async, active low)
//           enable, write_sample_in, spike_detection_array, event_out_array - capture side
//           evt_valid/evt_ready, evt_unit, evt_code, evt_timestamp        - event stream
//           drop_count, overflow, clear_overflow                           - loss tracking

module spike_event_arbiter
   import spike_event_pkg::*;
#(
   parameter int NUM_UNITS  = 4,
   parameter int EVT_WIDTH  = EVT_WIDTH_DEF,
   parameter int TS_WIDTH   = 16,
   parameter int DROP_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              write_sample_in,
   input  logic [NUM_UNITS-1:0]              spike_detection_array,
   input  logic [EVT_WIDTH*NUM_UNITS-1:0]    event_out_array,
   output logic                              evt_valid,
   input  logic                              evt_ready,
   output logic [unit_idx_w(NUM_UNITS)-1:0]  evt_unit,
   output logic [EVT_WIDTH-1:0]              evt_code,
   output logic [TS_WIDTH-1:0]               evt_timestamp,
   output logic [DROP_WIDTH-1:0]             drop_count,
   output logic                              overflow,
   input  logic                              clear_overflow
);

   localparam int UW = unit_idx_w(NUM_UNITS);

   logic [TS_WIDTH-1:0]   ts_cnt_q;
   logic [NUM_UNITS-1:0]  pending_q, pending_d;
   logic [EVT_WIDTH-1:0]  code_q    [NUM_UNITS];
   logic [TS_WIDTH-1:0]   slot_ts_q [NUM_UNITS];

   arb_state_e            state_q;
   logic [UW-1:0]         last_q;
   logic                  evt_valid_q;
   logic [UW-1:0]         evt_unit_q;
   logic [EVT_WIDTH-1:0]  evt_code_q;
   logic [TS_WIDTH-1:0]   evt_ts_q;
   logic [DROP_WIDTH-1:0] drop_q, drop_d;
   logic                  ovf_q, ovf_d;

   logic [UW-1:0]         gnt_idx;
   logic                  any_req;
   logic                  load;
   logic [NUM_UNITS-1:0]  accept;
   logic [NUM_UNITS-1:0]  drop;
   logic [DROP_WIDTH:0]   n_drop;
   logic [DROP_WIDTH:0]   drop_sum;

   // Only slots pending at the start of the cycle compete.
   rr_select #(.N(NUM_UNITS)) u_rr_select (
      .req     (pending_q),
      .last    (last_q),
      .gnt_idx (gnt_idx),
      .any     (any_req)
   );

   always_comb begin
      load      = any_req && ((state_q == ARB_IDLE) || evt_ready);
      accept    = '0;
      drop      = '0;
      pending_d = pending_q;
      n_drop    = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         // A slot emptied into the output register this edge can take a
         // fresh spike at the same edge.
         if (enable && spike_detection_array[i]) begin
            if (!pending_q[i] || (load && (gnt_idx == UW'(i)))) begin
               accept[i] = 1'b1;
            end else begin
               drop[i] = 1'b1;
            end
         end
         if (load && (gnt_idx == UW'(i))) begin
            pending_d[i] = 1'b0;
         end
         if (accept[i]) begin
            pending_d[i] = 1'b1;
         end
         n_drop = n_drop + (DROP_WIDTH + 1)'(drop[i]);
      end
      // Clear zeroes the base, so same-cycle drops still land.
      drop_sum = (clear_overflow ? '0 : {1'b0, drop_q}) + n_drop;
      drop_d   = drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
      ovf_d    = (clear_overflow ? 1'b0 : ovf_q) | (|drop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_cnt_q  <= '0;
         pending_q <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
         for (int i = 0; i < NUM_UNITS; i++) begin
            code_q[i]    <= '0;
            slot_ts_q[i] <= '0;
         end
      end else begin
         if (write_sample_in) begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
         end
         pending_q <= pending_d;
         drop_q    <= drop_d;
         ovf_q     <= ovf_d;
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (accept[i]) begin
               code_q[i]    <= event_out_array[EVT_WIDTH*i +: EVT_WIDTH];
               slot_ts_q[i] <= ts_cnt_q;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ARB_IDLE;
         last_q      <= UW'(NUM_UNITS - 1);
         evt_valid_q <= 1'b0;
         evt_unit_q  <= '0;
         evt_code_q  <= '0;
         evt_ts_q    <= '0;
      end else begin
         if (load) begin
            evt_unit_q <= gnt_idx;
            evt_code_q <= code_q[gnt_idx];
            evt_ts_q   <= slot_ts_q[gnt_idx];
            last_q     <= gnt_idx;
         end
         case (state_q)
            ARB_IDLE: begin
               if (load) begin
                  evt_valid_q <= 1'b1;
                  state_q     <= ARB_PRESENT;
               end
            end
            ARB_PRESENT: begin
               if (evt_ready && !load) begin
                  evt_valid_q <= 1'b0;
                  state_q     <= ARB_IDLE;
               end
            end
            default: begin
               evt_valid_q <= 1'b0;
               state_q     <= ARB_IDLE;
            end
         endcase
      end
   end

   assign evt_valid     = evt_valid_q;
   assign evt_unit      = evt_unit_q;
   assign evt_code      = evt_code_q;
   assign evt_timestamp = evt_ts_q;
   assign drop_count    = drop_q;
   assign overflow      = ovf_q;

endmodule
